// File: rtl/pc_rx_word_receiver.sv
// rtl/pc_rx_word_receiver.sv - UART 8N1 receiver assembling big-endian 32-bit words into a FWFT FIFO
module pc_rx_word_receiver #(
  parameter int CLKS_PER_BIT = 435,
  parameter int FIFO_DEPTH   = 4,
  parameter int TIMEOUT_BITS = 40
) (
  input  logic        i_clock,
  input  logic        i_reset,
  input  logic        i_UART_RX,
  output logic [31:0] o_word_data,
  output logic        o_word_valid,
  input  logic        i_word_ready,
  output logic        o_fifo_full,
  output logic        o_overflow,
  output logic        o_framing_error,
  output logic        o_rx_active
);

  localparam int TO_CLKS = TIMEOUT_BITS * CLKS_PER_BIT;
  localparam int CNT_W   = $clog2(TO_CLKS + 1);
  localparam int PTR_W   = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] HALF_BIT = CNT_W'(CLKS_PER_BIT / 2);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] TO_LAST  = CNT_W'(TO_CLKS - 1);
  localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
  localparam logic [PTR_W:0]   OCC_ONE  = (PTR_W + 1)'(1);
  localparam logic [PTR_W:0]   OCC_FULL = (PTR_W + 1)'(FIFO_DEPTH);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP,
    S_WAIT_HIGH
  } state_t;

  logic             r_rx_meta;
  logic             r_rx_sync;
  state_t           r_state;
  logic [CNT_W-1:0] r_bit_cnt;
  logic [CNT_W-1:0] r_to_cnt;
  logic [2:0]       r_bit_idx;
  logic [7:0]       r_shift;
  logic [1:0]       r_byte_idx;
  logic [23:0]      r_word;
  logic             r_push;
  logic [31:0]      r_push_word;
  logic             r_framing_error;
  logic             r_rx_active;

  logic [31:0]      r_mem [FIFO_DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [PTR_W:0]   r_count;
  logic             r_overflow;

  logic             w_full;
  logic             w_pop;
  logic             w_push_ok;

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      r_rx_meta <= 1'b1;
      r_rx_sync <= 1'b1;
    end else begin
      r_rx_meta <= i_UART_RX;
      r_rx_sync <= r_rx_meta;
    end
  end

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      r_state         <= S_IDLE;
      r_bit_cnt       <= '0;
      r_to_cnt        <= '0;
      r_bit_idx       <= '0;
      r_shift         <= '0;
      r_byte_idx      <= '0;
      r_word          <= '0;
      r_push          <= 1'b0;
      r_push_word     <= '0;
      r_framing_error <= 1'b0;
      r_rx_active     <= 1'b0;
    end else begin
      r_push          <= 1'b0;
      r_framing_error <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (!r_rx_sync) begin
            r_state     <= S_START;
            r_bit_cnt   <= '0;
            r_rx_active <= 1'b1;
          end else if (r_byte_idx != 2'd0) begin
            // Partial word abandoned when the next start bit is too late.
            if (r_to_cnt == TO_LAST) begin
              r_framing_error <= 1'b1;
              r_byte_idx      <= '0;
              r_to_cnt        <= '0;
            end else begin
              r_to_cnt <= r_to_cnt + CNT_ONE;
            end
          end
        end
        S_START: begin
          if (r_bit_cnt == HALF_BIT) begin
            r_bit_cnt <= '0;
            r_bit_idx <= '0;
            if (r_rx_sync) begin
              r_state     <= S_IDLE;
              r_rx_active <= 1'b0;
            end else begin
              r_state <= S_DATA;
            end
          end else begin
            r_bit_cnt <= r_bit_cnt + CNT_ONE;
          end
        end
        S_DATA: begin
          if (r_bit_cnt == LAST_BIT) begin
            r_bit_cnt <= '0;
            r_shift   <= {r_rx_sync, r_shift[7:1]};
            if (r_bit_idx == 3'd7) begin
              r_state <= S_STOP;
            end else begin
              r_bit_idx <= r_bit_idx + 3'd1;
            end
          end else begin
            r_bit_cnt <= r_bit_cnt + CNT_ONE;
          end
        end
        S_STOP: begin
          if (r_bit_cnt == LAST_BIT) begin
            r_bit_cnt   <= '0;
            r_to_cnt    <= '0;
            r_rx_active <= 1'b0;
            if (r_rx_sync) begin
              r_state <= S_IDLE;
              if (r_byte_idx == 2'd3) begin
                r_push      <= 1'b1;
                r_push_word <= {r_word, r_shift};
                r_byte_idx  <= '0;
              end else begin
                r_word     <= {r_word[15:0], r_shift};
                r_byte_idx <= r_byte_idx + 2'd1;
              end
            end else begin
              r_state         <= S_WAIT_HIGH;
              r_framing_error <= 1'b1;
              r_byte_idx      <= '0;
            end
          end else begin
            r_bit_cnt <= r_bit_cnt + CNT_ONE;
          end
        end
        S_WAIT_HIGH: begin
          if (r_rx_sync) begin
            r_state <= S_IDLE;
          end
        end
        default: begin
          r_state     <= S_IDLE;
          r_rx_active <= 1'b0;
        end
      endcase
    end
  end

  assign w_full    = (r_count == OCC_FULL);
  assign w_pop     = (r_count != '0) && i_word_ready;
  assign w_push_ok = r_push && (!w_full || w_pop);

  always_ff @(posedge i_clock) begin
    if (w_push_ok) begin
      r_mem[r_wr_ptr] <= r_push_word;
    end
  end

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
    end else begin
      r_overflow <= r_push && w_full && !w_pop;
      if (w_push_ok) begin
        r_wr_ptr <= r_wr_ptr + PTR_ONE;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_ONE;
      end
      case ({w_push_ok, w_pop})
        2'b10:   r_count <= r_count + OCC_ONE;
        2'b01:   r_count <= r_count - OCC_ONE;
        default: r_count <= r_count;
      endcase
    end
  end

  assign o_word_valid    = (r_count != '0);
  assign o_word_data     = o_word_valid ? r_mem[r_rd_ptr] : 32'd0;
  assign o_fifo_full     = w_full;
  assign o_overflow      = r_overflow;
  assign o_framing_error = r_framing_error;
  assign o_rx_active     = r_rx_active;

endmodule

// File: tb/tb_pc_rx_word_receiver.sv
// tb/tb_pc_rx_word_receiver.sv - randomized self-checking bench for pc_rx_word_receiver
module tb_pc_rx_word_receiver;
  localparam int CPB   = 16;
  localparam int DEPTH = 4;
  localparam int TOB   = 40;

  logic        clk = 1'b0;
  logic        rst;
  logic        rx;
  logic        ready;
  logic [31:0] o_word_data;
  logic        o_word_valid;
  logic        o_fifo_full;
  logic        o_overflow;
  logic        o_framing_error;
  logic        o_rx_active;

  pc_rx_word_receiver #(
    .CLKS_PER_BIT(CPB),
    .FIFO_DEPTH  (DEPTH),
    .TIMEOUT_BITS(TOB)
  ) dut (
    .i_clock        (clk),
    .i_reset        (rst),
    .i_UART_RX      (rx),
    .o_word_data    (o_word_data),
    .o_word_valid   (o_word_valid),
    .i_word_ready   (ready),
    .o_fifo_full    (o_fifo_full),
    .o_overflow     (o_overflow),
    .o_framing_error(o_framing_error),
    .o_rx_active    (o_rx_active)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Monitor: what the DUT actually delivers
  int          cyc = 0;
  logic [31:0] obs_q[$];
  int          ovf_cnt, fe_cnt, valid_cyc, act_cyc, fe_cyc;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (!rst) begin
      if (o_word_valid && ready) obs_q.push_back(o_word_data);
      if (o_overflow) ovf_cnt++;
      if (o_framing_error) begin
        fe_cnt++;
        fe_cyc = cyc;
      end
      if (o_word_valid) valid_cyc++;
      if (o_rx_active) act_cyc++;
    end
  end

  // Reference model: byte-level protocol rules, no cycle detail
  logic [31:0] exp_q[$];
  logic [7:0]  part[$];
  int          exp_fe, exp_ovf, held;
  bit          stall;

  task automatic clear_stats();
    obs_q.delete();
    exp_q.delete();
    ovf_cnt = 0; fe_cnt = 0; valid_cyc = 0; act_cyc = 0;
    exp_fe = 0; exp_ovf = 0;
  endtask

  task automatic model_byte(input logic [7:0] b, input bit good);
    logic [31:0] w;
    if (!good) begin
      part.delete();
      exp_fe++;
      return;
    end
    part.push_back(b);
    if (part.size() == 4) begin
      w = {part[0], part[1], part[2], part[3]};
      part.delete();
      if (stall && held == DEPTH) exp_ovf++;
      else begin
        if (stall) held++;
        exp_q.push_back(w);
      end
    end
  endtask

  task automatic wait_clks(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b, input bit good);
    rx = 1'b0;
    wait_clks(CPB);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      wait_clks(CPB);
    end
    rx = good;
    wait_clks(CPB);
    rx = 1'b1;
    model_byte(b, good);
  endtask

  task automatic send_word(input logic [31:0] w);
    for (int i = 3; i >= 0; i--) send_byte(w[8*i +: 8], 1'b1);
  endtask

  task automatic check_phase(input string tag);
    check_eq({tag, "_nwords"}, obs_q.size(), exp_q.size());
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++)
      check_eq($sformatf("%s_word%0d", tag, i), obs_q[i], exp_q[i]);
    check_eq({tag, "_ferr"}, fe_cnt, exp_fe);
    check_eq({tag, "_ovf"}, ovf_cnt, exp_ovf);
    clear_stats();
  endtask

  initial begin
    int t_end;
    bit done;
    rst = 1'b1; rx = 1'b1; ready = 1'b0; stall = 1'b0; held = 0;
    clear_stats();
    wait_clks(3);
    check_eq("rst_data", o_word_data, 32'd0);
    check_eq("rst_valid", o_word_valid, 1'b0);
    check_eq("rst_full", o_fifo_full, 1'b0);
    check_eq("rst_ovf", o_overflow, 1'b0);
    check_eq("rst_ferr", o_framing_error, 1'b0);
    check_eq("rst_active", o_rx_active, 1'b0);
    rst = 1'b0;
    wait_clks(5);

    ready = 1'b1;
    send_word(32'hDEADBEEF);
    wait_clks(40);
    check_eq("w1_valid_cycles", valid_cyc, 1);
    check_phase("w1");

    ready = 1'b0; stall = 1'b1; held = 0;
    for (int w = 1; w <= 5; w++) begin
      send_word(32'(w));
      wait_clks(5);
      if (w == 3) check_eq("ovf_full_after3", o_fifo_full, 1'b0);
      if (w == 4) check_eq("ovf_full_after4", o_fifo_full, 1'b1);
    end
    check_eq("ovf_still_full", o_fifo_full, 1'b1);
    ready = 1'b1; stall = 1'b0;
    wait_clks(20);
    check_eq("ovf_drained_full", o_fifo_full, 1'b0);
    check_phase("ovf");

    send_byte(8'h11, 1'b1);
    send_byte(8'h22, 1'b0);
    wait_clks(40);
    send_word(32'h01020304);
    wait_clks(40);
    check_phase("stopbit");

    rx = 1'b0;
    wait_clks(4);
    rx = 1'b1;
    wait_clks(60);
    check_eq("glitch_short_active", act_cyc < CPB, 1'b1);
    check_eq("glitch_idle", o_rx_active, 1'b0);
    check_phase("glitch");

    send_byte(8'hAA, 1'b1);
    send_byte(8'hBB, 1'b1);
    t_end = cyc;
    wait_clks(700);
    part.delete();
    exp_fe++;
    check_eq("timeout_delay_ok", (fe_cyc - t_end >= 620) && (fe_cyc - t_end <= 650), 1'b1);
    send_word(32'h11223344);
    wait_clks(40);
    check_phase("timeout");

    done = 1'b0;
    fork
      begin
        for (int n = 0; n < 80; n++) begin
          logic [7:0] b;
          bit good;
          b = 8'($urandom);
          good = ($urandom_range(0, 9) != 0);
          send_byte(b, good);
          wait_clks($urandom_range(4, 200));
        end
        wait_clks(40);
        done = 1'b1;
      end
      begin
        while (!done) begin
          @(posedge clk);
          #1 ready = $urandom_range(0, 1);
        end
        ready = 1'b1;
      end
    join
    wait_clks(20);
    part.delete();
    check_phase("rand");
    wait_clks(TOB * CPB + 20);
    clear_stats();

    ready = 1'b0;
    send_word(32'h12345678);
    send_byte(8'h01, 1'b1);
    send_byte(8'h02, 1'b1);
    rx = 1'b0;
    wait_clks(CPB);
    rx = 1'b1;
    wait_clks(3 * CPB);
    #2 rst = 1'b1;
    #1;
    check_eq("rstmid_valid", o_word_valid, 1'b0);
    check_eq("rstmid_data", o_word_data, 32'd0);
    check_eq("rstmid_active", o_rx_active, 1'b0);
    wait_clks(5);
    rst = 1'b0;
    part.delete();
    clear_stats();
    wait_clks(5);
    ready = 1'b1;
    send_word(32'hCAFEBABE);
    wait_clks(40);
    check_phase("rstmid");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
